uart_frame_core: RTL
====================

UART_FRAME_CORE -- requirements
Module: uart_frame_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, 50000000, clk_int frequency in Hz.
REQ-002 SHALL have parameter DATA_BITS, 8, frame data width; legal range 5..9.
REQ-003 SHALL have parameter OVERSAMPLE, 16, sample ticks per bit; even, >= 8.
REQ-004 SHALL have port clk_int  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port uart_reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port freq_control  input  2  baud select: 00=9600, 01=19200, 10=57600, 11=115200.
REQ-007 SHALL have port parity_mode  input  2  00=none, 01=even, 10=odd, 11=none.
REQ-008 SHALL have port stop2  input  1  1 = two stop bits on TX; RX always checks the first stop bit only.
REQ-009 SHALL have port loopback  input  1  1 = RX receives the internal TX line.
REQ-010 SHALL have port uart_tx_data  input  DATA_BITS  byte to send, LSB first.
REQ-011 SHALL have port uart_tx_start  input  1  send request.
REQ-012 SHALL have port uart_tx_ready  output  1  TX idle and able to accept a request.
REQ-013 SHALL have port uart_tx_d_out  output  1  serial TX line, idle high.
REQ-014 SHALL have port uart_rx_d_in  input  1  asynchronous serial RX line.
REQ-015 SHALL have port uart_rx_data  output  DATA_BITS  last received word.
REQ-016 SHALL have port uart_rx_valid  output  1  one-cycle pulse when a frame completes.
REQ-017 SHALL have port uart_rx_parity_err  output  1  parity mismatch for the current uart_rx_data.
REQ-018 SHALL have port uart_rx_frame_err  output  1  stop bit sampled low for the current uart_rx_data.

Function
REQ-019 SHALL derive four divisors as localparams: DIV = (CLK_FREQ + B*OVERSAMPLE/2) / (B*OVERSAMPLE) for each baud B. At 50 MHz, 9600 baud gives DIV=326, and one bit lasts 5216 clocks.
REQ-020 SHALL produce one sample tick every DIV clocks from a free-running counter. The counter reloads when freq_control changes.
REQ-021 SHALL have a TX FSM with states IDLE, START, DATA, PARITY, STOP; each state lasts OVERSAMPLE sample ticks per bit.
REQ-022 SHALL, in IDLE with uart_tx_start=1, latch uart_tx_data, parity_mode and stop2, then enter START; uart_tx_ready SHALL go 0 on the next clock.
REQ-023 SHALL drive uart_tx_d_out as follows: 0 in START, data[i] in DATA, parity bit in PARITY, 1 in STOP and IDLE.
REQ-024 SHALL skip PARITY when the latched parity_mode is none, and hold STOP for 2 bits when the latched stop2=1.
REQ-025 SHALL return to IDLE after STOP and raise uart_tx_ready; a start held high SHALL begin the next frame back-to-back.
REQ-026 SHALL ignore input changes to data or configuration during a frame; only the values latched at start apply.
REQ-027 SHALL pass uart_rx_d_in through a 2-flop synchronizer, or select the internal TX line when loopback=1.
REQ-028 SHALL hold uart_tx_d_out at 1 while loopback=1, with the internal TX line still running.
REQ-029 SHALL have an RX FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-030 SHALL leave RX IDLE on a synchronized falling edge and enter START.
REQ-031 SHALL re-check the line in START after OVERSAMPLE/2 ticks: if the line is high, treat it as a glitch and return to IDLE with no outputs changed.
REQ-032 SHALL sample each subsequent bit at mid-bit, i.e. every OVERSAMPLE ticks from the verified start centre.
REQ-033 SHALL, at the mid-point of STOP, update uart_rx_data, uart_rx_parity_err and uart_rx_frame_err, and pulse uart_rx_valid for exactly 1 clock, even when errors are present.
REQ-034 SHALL, after a frame error, wait for the line to be high before re-arming falling-edge detection.
REQ-035 SHALL keep uart_rx_data and the error flags stable until the next uart_rx_valid pulse.
REQ-036 SHALL run TX and RX independently, so simultaneous TX and RX traffic is supported.

Reset
REQ-037 SHALL, while uart_reset=0, immediately force both FSMs to IDLE and set outputs to: uart_tx_d_out=1, uart_tx_ready=1, uart_rx_valid=0, uart_rx_data=0, both error flags 0, counters 0, synchronizer flops 1.
REQ-038 SHALL abort any frame in progress on reset mid-frame and emit no partial uart_rx_valid pulse.
REQ-039 SHALL resume operation on the first clock after uart_reset returns to 1.

Verification
REQ-040 SHALL cover: 50 MHz, freq_control=00, 8N1, external drive of 0xA9 on uart_rx_d_in at 104160 ns/bit -> one uart_rx_valid pulse, uart_rx_data=0xA9, both error flags 0.
REQ-041 SHALL cover: loopback=1, parity_mode=01, uart_tx_start pulsed with 0x5A -> uart_tx_ready low for 11 bit-times (57376 clocks), received 0x5A, parity_err=0, uart_tx_d_out constant 1.
REQ-042 SHALL cover: external frame 0x3C with even parity bit forced wrong -> uart_rx_valid pulse, data=0x3C, parity_err=1, frame_err=0.
REQ-043 SHALL cover: external 8N1 frame 0x81 with stop bit 0 -> frame_err=1; no new frame accepted until the line has been high.
REQ-044 SHALL cover: a 3-tick low glitch on uart_rx_d_in -> no uart_rx_valid pulse; the following valid frame 0x55 is received correctly.
REQ-045 SHALL cover: uart_reset pulsed low during TX bit 4 at 115200 baud -> uart_tx_d_out=1 and uart_tx_ready=1 without waiting for a clock edge; the next start sends a full correct frame.

Source files
------------

// File: rtl/uart_frame_core.sv
// UART framing core: oversampled baud tick, TX/RX frame FSMs, loopback and
// 2-flop RX synchronizer. Configuration is latched per frame.
//
// TX/RX state | meaning
// IDLE        | line idle (TX: ready for a request, RX: waiting for falling edge)
// START       | start bit (RX: waits half a bit, then re-checks for a glitch)
// DATA        | data bits, LSB first
// PARITY      | parity bit (skipped when parity is off)
// STOP        | stop bit(s); RX publishes its result at mid-stop
module uart_frame_core #(
  parameter int CLK_FREQ   = 50000000,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_int,
  input  logic                 uart_reset,
  input  logic [1:0]           freq_control,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 loopback,
  input  logic [DATA_BITS-1:0] uart_tx_data,
  input  logic                 uart_tx_start,
  output logic                 uart_tx_ready,
  output logic                 uart_tx_d_out,
  input  logic                 uart_rx_d_in,
  output logic [DATA_BITS-1:0] uart_rx_data,
  output logic                 uart_rx_valid,
  output logic                 uart_rx_parity_err,
  output logic                 uart_rx_frame_err
);

  localparam int DIV_9600   = (CLK_FREQ + 9600 * OVERSAMPLE / 2) / (9600 * OVERSAMPLE);
  localparam int DIV_19200  = (CLK_FREQ + 19200 * OVERSAMPLE / 2) / (19200 * OVERSAMPLE);
  localparam int DIV_57600  = (CLK_FREQ + 57600 * OVERSAMPLE / 2) / (57600 * OVERSAMPLE);
  localparam int DIV_115200 = (CLK_FREQ + 115200 * OVERSAMPLE / 2) / (115200 * OVERSAMPLE);
  localparam int CW = $clog2(DIV_9600 + 1);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // baud tick: down-counter reloaded on terminal count or baud change
  logic [1:0]    freq_q;
  logic [CW-1:0] cnt_q, cnt_d, div_m1;
  logic          tick;

  always_comb begin
    case (freq_control)
      2'b00:   div_m1 = CW'(DIV_9600 - 1);
      2'b01:   div_m1 = CW'(DIV_19200 - 1);
      2'b10:   div_m1 = CW'(DIV_57600 - 1);
      default: div_m1 = CW'(DIV_115200 - 1);
    endcase
    tick  = (cnt_q == '0);
    cnt_d = cnt_q - 1'b1;
    if (tick || (freq_control != freq_q)) cnt_d = div_m1;
  end

  // TX
  state_t                tx_state_q, tx_state_d;
  logic [TW-1:0]         tx_tcnt_q, tx_tcnt_d;
  logic [BW-1:0]         tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_par_en_q, tx_par_en_d;
  logic                  tx_stop2_q, tx_stop2_d;
  logic                  tx_line, tx_bit_end;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_tcnt_d   = tx_tcnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_par_en_d = tx_par_en_q;
    tx_stop2_d  = tx_stop2_q;
    tx_line     = 1'b1;
    tx_bit_end  = tick && (tx_tcnt_q == '0);
    if ((tx_state_q != S_IDLE) && tick) tx_tcnt_d = tx_bit_end ? TC_FULL : tx_tcnt_q - 1'b1;
    case (tx_state_q)
      S_IDLE: begin
        if (uart_tx_start) begin
          tx_shift_d  = uart_tx_data;
          tx_par_d    = (^uart_tx_data) ^ parity_mode[1];
          tx_par_en_d = parity_mode[0] ^ parity_mode[1];
          tx_stop2_d  = stop2;
          tx_tcnt_d   = TC_FULL;
          tx_state_d  = S_START;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) begin
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_line = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == BIT_LAST) begin
            tx_bit_d   = '0;
            tx_state_d = tx_par_en_q ? S_PARITY : S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        tx_line = tx_par_q;
        if (tx_bit_end) begin
          tx_bit_d   = '0;
          tx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          if (tx_stop2_q && (tx_bit_q == '0)) tx_bit_d = BW'(1);
          else                                tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  assign uart_tx_ready = (tx_state_q == S_IDLE);
  assign uart_tx_d_out = loopback | tx_line;

  // RX
  state_t                rx_state_q, rx_state_d;
  logic [TW-1:0]         rx_tcnt_q, rx_tcnt_d;
  logic [BW-1:0]         rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  rx_par_en_q, rx_par_en_d;
  logic                  rx_odd_q, rx_odd_d;
  logic                  rx_perr_acc_q, rx_perr_acc_d;
  logic                  sync1_q, sync2_q, rx_prev_q;
  logic                  rx_line, rx_fall, rx_bit_end;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_ferr_q, rx_ferr_d;

  assign rx_line = loopback ? tx_line : sync2_q;
  // edge needs a high previous sample, so a low line after a frame error cannot re-arm
  assign rx_fall = rx_prev_q & ~rx_line;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_tcnt_d     = rx_tcnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_par_en_d   = rx_par_en_q;
    rx_odd_d      = rx_odd_q;
    rx_perr_acc_d = rx_perr_acc_q;
    rx_data_d     = rx_data_q;
    rx_perr_d     = rx_perr_q;
    rx_ferr_d     = rx_ferr_q;
    rx_valid_d    = 1'b0;
    rx_bit_end    = tick && (rx_tcnt_q == '0);
    if ((rx_state_q != S_IDLE) && tick) rx_tcnt_d = rx_bit_end ? TC_FULL : rx_tcnt_q - 1'b1;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_fall) begin
          rx_tcnt_d     = TC_HALF;
          rx_par_en_d   = parity_mode[0] ^ parity_mode[1];
          rx_odd_d      = parity_mode[1];
          rx_perr_acc_d = 1'b0;
          rx_state_d    = S_START;
        end
      end
      S_START: begin
        if (rx_bit_end) begin
          rx_bit_d   = '0;
          rx_state_d = rx_line ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) rx_state_d = rx_par_en_q ? S_PARITY : S_STOP;
          else                      rx_bit_d   = rx_bit_q + BW'(1);
        end
      end
      S_PARITY: begin
        if (rx_bit_end) begin
          rx_perr_acc_d = rx_line ^ (^rx_shift_q) ^ rx_odd_q;
          rx_state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_bit_end) begin
          rx_data_d  = rx_shift_q;
          rx_perr_d  = rx_par_en_q & rx_perr_acc_q;
          rx_ferr_d  = ~rx_line;
          rx_valid_d = 1'b1;
          rx_state_d = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) begin
      freq_q        <= '0;
      cnt_q         <= '0;
      tx_state_q    <= S_IDLE;
      tx_tcnt_q     <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_par_q      <= 1'b0;
      tx_par_en_q   <= 1'b0;
      tx_stop2_q    <= 1'b0;
      rx_state_q    <= S_IDLE;
      rx_tcnt_q     <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_en_q   <= 1'b0;
      rx_odd_q      <= 1'b0;
      rx_perr_acc_q <= 1'b0;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      freq_q        <= freq_control;
      cnt_q         <= cnt_d;
      tx_state_q    <= tx_state_d;
      tx_tcnt_q     <= tx_tcnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      tx_par_q      <= tx_par_d;
      tx_par_en_q   <= tx_par_en_d;
      tx_stop2_q    <= tx_stop2_d;
      rx_state_q    <= rx_state_d;
      rx_tcnt_q     <= rx_tcnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_par_en_q   <= rx_par_en_d;
      rx_odd_q      <= rx_odd_d;
      rx_perr_acc_q <= rx_perr_acc_d;
      sync1_q       <= uart_rx_d_in;
      sync2_q       <= sync1_q;
      rx_prev_q     <= rx_line;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_perr_q     <= rx_perr_d;
      rx_ferr_q     <= rx_ferr_d;
    end
  end

  assign uart_rx_data       = rx_data_q;
  assign uart_rx_valid      = rx_valid_q;
  assign uart_rx_parity_err = rx_perr_q;
  assign uart_rx_frame_err  = rx_ferr_q;

endmodule
